// File: rtl/gpr_file.sv
// gpr_file: 32 x 32-bit MIPS GPR file with $0 hardwired to zero, two combinational
// read ports with write bypass, one write port. Define GPR_RESET_CLEAR_EN for the post-reset clear sequencer.
module gpr_file #(
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic        busy_o,
  output logic        wr_drop_o
);

  // Entry 0 exists only to keep indexing simple; it is never written or returned.
  logic [31:0] mem_q [32];
  logic        clr_wr_s;
  logic [4:0]  clr_addr_s;

`ifdef GPR_RESET_CLEAR_EN
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e     state_q;
  logic [4:0] clr_ptr_q;
  logic       wr_drop_q;

  // Clear sequencer: walks $1..$31 once after every reset, holding at 31 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= 5'd1;
      wr_drop_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          wr_drop_q <= we;
          if (clr_ptr_q == 5'd31) begin
            state_q <= IDLE;
          end else begin
            clr_ptr_q <= clr_ptr_q + 5'd1;
          end
        end
        IDLE: begin
          wr_drop_q <= 1'b0;
        end
        default: begin
          state_q   <= CLEAR;
          clr_ptr_q <= 5'd1;
          wr_drop_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_wr_s   = (state_q == CLEAR);
  assign clr_addr_s = clr_ptr_q;
  assign busy_o     = rst | (state_q == CLEAR);
  assign wr_drop_o  = wr_drop_q;
`else
  assign clr_wr_s   = 1'b0;
  assign clr_addr_s = 5'd0;
  assign busy_o     = 1'b0;
  assign wr_drop_o  = 1'b0;
`endif

  // Array update: the clear write always wins over the external write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr_s) begin
        mem_q[clr_addr_s] <= CLR_VALUE;
      end else if (we && (waddr != 5'd0)) begin
        mem_q[waddr] <= wdata;
      end else begin
        mem_q[0] <= mem_q[0];
      end
    end else begin
      mem_q[0] <= mem_q[0];
    end
  end

  // Read port 1 priority chain; busy_o is constant 0 when the sequencer is absent.
  always_comb begin
    rdata1 = 32'h0000_0000;
    if (rst || !re1 || (raddr1 == 5'd0)) begin
      rdata1 = 32'h0000_0000;
    end else if (busy_o) begin
      rdata1 = CLR_VALUE;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_q[raddr1];
    end
  end

  // Read port 2 priority chain, identical to port 1.
  always_comb begin
    rdata2 = 32'h0000_0000;
    if (rst || !re2 || (raddr2 == 5'd0)) begin
      rdata2 = 32'h0000_0000;
    end else if (busy_o) begin
      rdata2 = CLR_VALUE;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_q[raddr2];
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic
// against an array-based reference model. Follows GPR_RESET_CLEAR_EN like the design.
`timescale 1ns/1ps
module tb_gpr_file;

  localparam logic [31:0] CLR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy_o, wr_drop_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  int          clear_left = 0;
  logic        drop_exp = 1'b0;

  always #5 clk = ~clk;

  gpr_file #(.CLR_VALUE(CLR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .busy_o(busy_o), .wr_drop_o(wr_drop_o)
  );

  function automatic logic m_busy();
`ifdef GPR_RESET_CLEAR_EN
    return rst || (clear_left > 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0000_0000;
    if (m_busy()) return CLR;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic r_c, w_c;
    logic [4:0] a_c;
    logic [31:0] d_c;
    r_c = rst; w_c = we; a_c = waddr; d_c = wdata;
    @(posedge clk);
    if (r_c) begin
      drop_exp = 1'b0;
`ifdef GPR_RESET_CLEAR_EN
      clear_left = 31;
`endif
    end else if (clear_left > 0) begin
      m_mem[32 - clear_left] = CLR;
      clear_left--;
      drop_exp = w_c;
    end else begin
      drop_exp = 1'b0;
      if (w_c && a_c != 5'd0) m_mem[a_c] = d_c;
    end
    #1;
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o === 1'b1) cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != 31) begin
      n_err++;
      $display("FAIL %s: busy cycles got %0d expected 31", name, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = $urandom;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd4;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL rst_rdata1: got %h expected 0", rdata1); end
    n_cmp++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL rst_rdata2: got %h expected 0", rdata2); end
`ifdef GPR_RESET_CLEAR_EN
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b expected 1", busy_o); end
`else
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
`endif
    tick();
    n_cmp++; if (wr_drop_o !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b expected 0", wr_drop_o); end
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
`ifdef GPR_RESET_CLEAR_EN
    count_busy("rst_busy_len");
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy_end: got %b expected 0", busy_o); end
`else
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy_rel: got %b expected 0", busy_o); end
    we = 1'b1; waddr = 5'd1; wdata = 32'h0BAD_F00D;
    tick();
    we = 1'b0; raddr1 = 5'd1;
    #1;
    n_cmp++; if (rdata1 !== 32'h0BAD_F00D) begin n_err++; $display("FAIL first_write: got %h expected 0badf00d", rdata1); end
`endif
  endtask

  task automatic test_init();
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; waddr = a[4:0]; wdata = $urandom;
      tick();
    end
    we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    for (int a = 1; a < 32; a++) begin
      raddr1 = a[4:0]; raddr2 = 5'(32 - a);
      #1;
      n_cmp++; if (rdata1 !== m_mem[a]) begin n_err++; $display("FAIL init_p1[%0d]: got %h expected %h", a, rdata1, m_mem[a]); end
      n_cmp++; if (rdata2 !== m_mem[32 - a]) begin n_err++; $display("FAIL init_p2[%0d]: got %h expected %h", 32 - a, rdata2, m_mem[32 - a]); end
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_p1: got %h expected 12345678", rdata1); end
    n_cmp++; if (rdata2 !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_p2: got %h expected 12345678", rdata2); end
    tick();
    we = 1'b0;
    #1;
    n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL stored_p1: got %h expected 12345678", rdata1); end
    n_cmp++; if (rdata2 !== 32'h1234_5678) begin n_err++; $display("FAIL stored_p2: got %h expected 12345678", rdata2); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL zero_same: got %h expected 0", rdata1); end
    tick();
    we = 1'b0;
    #1;
    n_cmp++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL zero_next: got %h expected 0", rdata2); end
    n_cmp++; if (wr_drop_o !== 1'b0) begin n_err++; $display("FAIL zero_drop: got %b expected 0", wr_drop_o); end
  endtask

  task automatic test_read_enable();
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
    tick();
    we = 1'b0; re2 = 1'b0; raddr2 = 5'd9;
    #1;
    n_cmp++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL re_low: got %h expected 0", rdata2); end
    re2 = 1'b1;
    #1;
    n_cmp++; if (rdata2 !== 32'h0000_0099) begin n_err++; $display("FAIL re_high: got %h expected 00000099", rdata2); end
  endtask

`ifdef GPR_RESET_CLEAR_EN
  task automatic test_reset_clear();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    n_cmp++; if (rdata1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL preload5: got %h expected deadbeef", rdata1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    count_busy("clear_busy_len");
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL clear5: got %h expected 0", rdata1); end
    for (int a = 1; a < 32; a++) begin
      raddr1 = a[4:0];
      #1;
      n_cmp++; if (rdata1 !== CLR) begin n_err++; $display("FAIL clear_all[%0d]: got %h expected %h", a, rdata1, CLR); end
    end
  endtask

  task automatic test_drop_clear();
    int budget;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
    tick();
    we = 1'b0;
    n_cmp++; if (wr_drop_o !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b expected 1", wr_drop_o); end
    tick();
    n_cmp++; if (wr_drop_o !== 1'b0) begin n_err++; $display("FAIL drop_one_cycle: got %b expected 0", wr_drop_o); end
    budget = 0;
    while (busy_o !== 1'b0 && budget < 40) begin
      tick();
      budget++;
    end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL drop_clear_end: busy got %b expected 0", busy_o); end
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL drop_reg3: got %h expected 0", rdata1); end
  endtask

  task automatic test_reset_mid_clear();
    we = 1'b1; waddr = 5'd20; wdata = 32'h0000_0014;
    tick();
    we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    count_busy("midclr_busy_len");
    re1 = 1'b1; raddr1 = 5'd20;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL midclr_reg20: got %h expected 0", rdata1); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      we = $urandom_range(0, 1);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0);
      re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e1 = m_read(re1, raddr1);
      e2 = m_read(re2, raddr2);
      n_cmp++; if (rdata1 !== e1) begin n_err++; $display("FAIL rand_p1 #%0d: got %h expected %h", i, rdata1, e1); end
      n_cmp++; if (rdata2 !== e2) begin n_err++; $display("FAIL rand_p2 #%0d: got %h expected %h", i, rdata2, e2); end
      n_cmp++; if (busy_o !== m_busy()) begin n_err++; $display("FAIL rand_busy #%0d: got %b expected %b", i, busy_o, m_busy()); end
      tick();
      n_cmp++; if (wr_drop_o !== drop_exp) begin n_err++; $display("FAIL rand_drop #%0d: got %b expected %b", i, wr_drop_o, drop_exp); end
    end
    rst = 1'b0; we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    test_reset();
    test_init();
    test_bypass();
    test_zero_reg();
    test_read_enable();
`ifdef GPR_RESET_CLEAR_EN
    test_reset_clear();
    test_drop_clear();
    test_reset_mid_clear();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
